// File: rtl/tiny_dnn_pkg.sv
// Shared FSM encoding, configuration snapshot layout and address-width defaults
// for the tiny DNN loop/address controller.
package tiny_dnn_pkg;

  localparam int AW_DEF = 12;
  localparam int WW_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Layer configuration as captured at layer start; loop fields hold count-1.
  typedef struct packed {
    logic [3:0] id;
    logic [3:0] od;
    logic [4:0] kh;
    logic [4:0] kw;
    logic [4:0] iw;
    logic [4:0] oh;
    logic [4:0] ow;
    logic [9:0] is_s;
    logic [9:0] os_s;
    logic [9:0] ks_s;
    logic [9:0] fs_s;
    logic       enb;
  } cfg_t;

endpackage

// File: rtl/tiny_dnn_cnt.sv
// One loop level: counts 0..max_i when en_i is high and wraps to 0; carry_o flags the wrapping step.
// Carry is combinational from the enable, so a chain of these ripples within one cycle.
module tiny_dnn_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] val_o,
  output logic         carry_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign val_o   = cnt_q;
  assign carry_o = en_i && (cnt_q == max_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == max_i) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tiny_dnn_ctrl.sv
// Convolution loop sequencer emitting ia/wa/oa per MAC step; first step 2 cycles after run rises, one step per
// cycle, outputs held while v_ready is low. Optional per-pixel bias step under TINY_DNN_CTRL_BIAS_EN.
module tiny_dnn_ctrl
  import tiny_dnn_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int WW = WW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          enbias,
  input  logic [3:0]    id,
  input  logic [3:0]    od,
  input  logic [4:0]    kh,
  input  logic [4:0]    kw,
  input  logic [4:0]    iw,
  input  logic [4:0]    oh,
  input  logic [4:0]    ow,
  input  logic [9:0]    is,
  input  logic [9:0]    os,
  input  logic [9:0]    ks,
  input  logic [9:0]    fs,
  output logic          v_valid,
  input  logic          v_ready,
  output logic [AW-1:0] ia,
  output logic [WW-1:0] wa,
  output logic [AW-1:0] oa,
  output logic          first,
  output logic          lastt,
  output logic          bias,
  output logic          busy,
  output logic          done
);

  state_e state_q, state_d;
  logic   run_q, run_qq;
  cfg_t   cfg_q, cfg_d;

  logic start, in_run, acc, tap_acc;
  logic bph_q;

  logic [4:0] kx, ky, x, unused_y;
  logic [3:0] c, d;
  logic       kx_cy, ky_cy, c_cy, x_cy, y_cy, d_cy;

  // Running products of loop index and stride, one per address term.
  logic [AW-1:0] tci_q, tci_d, tki_q, tki_d, tyi_q, tyi_d;
  logic [AW-1:0] tyo_q, tyo_d, tdo_q, tdo_d;
  logic [WW-1:0] tcw_q, tcw_d, tkw_q, tkw_d, tdw_q, tdw_d;
  logic [AW-1:0] irow, orow;
  logic [WW-1:0] krow;

  assign start   = (state_q == ST_IDLE) && run_q && !run_qq;
  assign in_run  = (state_q == ST_RUN);
  assign acc     = in_run && v_ready;
  assign tap_acc = acc && !bph_q;

  always_comb begin
    cfg_d = cfg_q;
    if (start) begin
      cfg_d.id   = id;
      cfg_d.od   = od;
      cfg_d.kh   = kh;
      cfg_d.kw   = kw;
      cfg_d.iw   = iw;
      cfg_d.oh   = oh;
      cfg_d.ow   = ow;
      cfg_d.is_s = is;
      cfg_d.os_s = os;
      cfg_d.ks_s = ks;
      cfg_d.fs_s = fs;
`ifdef TINY_DNN_CTRL_BIAS_EN
      cfg_d.enb  = enbias;
`else
      cfg_d.enb  = 1'b0;
`endif
    end
  end

  // Loop nest, kx innermost; each carry enables the next outer level.
  tiny_dnn_cnt #(.W(5)) u_kx (.clk(clk), .reset(reset), .clr_i(start), .en_i(tap_acc),
                              .max_i(cfg_q.kw), .val_o(kx), .carry_o(kx_cy));
  tiny_dnn_cnt #(.W(5)) u_ky (.clk(clk), .reset(reset), .clr_i(start), .en_i(kx_cy),
                              .max_i(cfg_q.kh), .val_o(ky), .carry_o(ky_cy));
  tiny_dnn_cnt #(.W(4)) u_c  (.clk(clk), .reset(reset), .clr_i(start), .en_i(ky_cy),
                              .max_i(cfg_q.id), .val_o(c), .carry_o(c_cy));
  tiny_dnn_cnt #(.W(5)) u_x  (.clk(clk), .reset(reset), .clr_i(start), .en_i(c_cy),
                              .max_i(cfg_q.ow), .val_o(x), .carry_o(x_cy));
  tiny_dnn_cnt #(.W(5)) u_y  (.clk(clk), .reset(reset), .clr_i(start), .en_i(x_cy),
                              .max_i(cfg_q.oh), .val_o(unused_y), .carry_o(y_cy));
  tiny_dnn_cnt #(.W(4)) u_d  (.clk(clk), .reset(reset), .clr_i(start), .en_i(y_cy),
                              .max_i(cfg_q.od), .val_o(d), .carry_o(d_cy));

  assign irow = AW'(cfg_q.iw) + AW'(1);
  assign orow = AW'(cfg_q.ow) + AW'(1);
  assign krow = WW'(cfg_q.kw) + WW'(1);

  function automatic logic [AW-1:0] step_a(input logic [AW-1:0] cur, input logic [AW-1:0] inc,
                                           input logic en, input logic wrap);
    return !en ? cur : (wrap ? '0 : cur + inc);
  endfunction

  function automatic logic [WW-1:0] step_w(input logic [WW-1:0] cur, input logic [WW-1:0] inc,
                                           input logic en, input logic wrap);
    return !en ? cur : (wrap ? '0 : cur + inc);
  endfunction

  always_comb begin
    tci_d = step_a(tci_q, AW'(cfg_q.is_s), ky_cy, c_cy);
    tcw_d = step_w(tcw_q, WW'(cfg_q.ks_s), ky_cy, c_cy);
    tki_d = step_a(tki_q, irow, kx_cy, ky_cy);
    tkw_d = step_w(tkw_q, krow, kx_cy, ky_cy);
    tyi_d = step_a(tyi_q, irow, x_cy, y_cy);
    tyo_d = step_a(tyo_q, orow, x_cy, y_cy);
    tdo_d = step_a(tdo_q, AW'(cfg_q.os_s), y_cy, d_cy);
    tdw_d = step_w(tdw_q, WW'(cfg_q.fs_s), y_cy, d_cy);
    if (start) begin
      tci_d = '0;
      tcw_d = '0;
      tki_d = '0;
      tkw_d = '0;
      tyi_d = '0;
      tyo_d = '0;
      tdo_d = '0;
      tdw_d = '0;
    end
  end

`ifdef TINY_DNN_CTRL_BIAS_EN
  logic bph_d;

  // Bias phase: set at the start of every pixel, cleared once its bias step is taken.
  always_comb begin
    bph_d = bph_q;
    if (start) begin
      bph_d = enbias;
    end else if (acc && bph_q) begin
      bph_d = 1'b0;
    end else if (c_cy) begin
      bph_d = cfg_q.enb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bph_q <= 1'b0;
    else       bph_q <= bph_d;
  end
`else
  logic unused_enbias;
  assign bph_q         = 1'b0;
  assign unused_enbias = enbias;
`endif

  always_comb begin
    state_d = state_q;
    v_valid = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        v_valid = 1'b1;
        if (!run)      state_d = ST_IDLE;
        else if (d_cy) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    first = 1'b0;
    lastt = 1'b0;
    bias  = 1'b0;
    if (in_run) begin
      bias  = bph_q;
      first = cfg_q.enb ? bph_q : (c == '0 && ky == '0 && kx == '0);
      lastt = !bph_q && (c == cfg_q.id) && (ky == cfg_q.kh) && (kx == cfg_q.kw);
    end
    ia = bph_q ? '0 : tci_q + tyi_q + tki_q + AW'(x) + AW'(kx);
    wa = bph_q ? WW'(d) : tdw_q + tcw_q + tkw_q + WW'(kx);
    oa = tdo_q + tyo_q + AW'(x);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      run_qq  <= 1'b0;
      cfg_q   <= '0;
      tci_q   <= '0;
      tcw_q   <= '0;
      tki_q   <= '0;
      tkw_q   <= '0;
      tyi_q   <= '0;
      tyo_q   <= '0;
      tdo_q   <= '0;
      tdw_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run;
      run_qq  <= run_q;
      cfg_q   <= cfg_d;
      tci_q   <= tci_d;
      tcw_q   <= tcw_d;
      tki_q   <= tki_d;
      tkw_q   <= tkw_d;
      tyi_q   <= tyi_d;
      tyo_q   <= tyo_d;
      tdo_q   <= tdo_d;
      tdw_q   <= tdw_d;
    end
  end

endmodule

// File: doc/tiny_dnn_ctrl.md
TINY_DNN_CTRL -- requirements
Module: tiny_dnn_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12: width of ia and oa.
REQ-002 SHALL have parameter WW, default 10: width of wa.
REQ-003 SHALL have ports `clk` (input, 1, sole clock) and `reset` (input, 1, asynchronous, active-high).
REQ-004 SHALL have `run` (input, 1): level enable from the register block. A rising edge starts a layer; low aborts it.
REQ-005 SHALL have `enbias` (input, 1): request a bias step per pixel.
REQ-006 SHALL have inputs `id[3:0]`, `od[3:0]`, `kh[4:0]`, `kw[4:0]`, `iw[4:0]`, `oh[4:0]`, `ow[4:0]`. Each encodes count-1.
REQ-007 SHALL have inputs `is[9:0]`, `os[9:0]`, `ks[9:0]`, `fs[9:0]`: strides in words for input channel, output channel, kernel plane and filter.
REQ-008 SHALL have `v_valid` (output, 1): a step is presented.
REQ-009 SHALL have `v_ready` (input, 1): the datapath accepts the step.
REQ-010 SHALL have outputs `ia[AW-1:0]`, `wa[WW-1:0]`, `oa[AW-1:0]`: input, weight and output addresses of the step.
REQ-011 SHALL have outputs `first` and `lastt` (1 each): first and last step of the current output pixel.
REQ-012 SHALL have `bias` (output, 1): the step is a bias step.
REQ-013 SHALL have `busy` (output, 1): the FSM is not in IDLE.
REQ-014 SHALL have `done` (output, 1): one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 SHALL capture `run` in a register. IDLE->RUN occurs on the cycle after `run` is sampled 0 then 1.
REQ-017 SHALL sample all configuration inputs at IDLE->RUN and hold them constant until IDLE.
REQ-018 SHALL nest loops d(od) > y(oh) > x(ow) > c(id) > ky(kh) > kx(kw), with kx innermost. Each loop wraps to 0 at count-1 and carries to the next outer loop.
REQ-019 SHALL compute ia = c*is + (y+ky)*(iw+1) + (x+kx).
REQ-020 SHALL compute wa = d*fs + c*ks + ky*(kw+1) + kx.
REQ-021 SHALL compute oa = d*os + y*(ow+1) + x.
REQ-022 SHALL compute all addresses incrementally with adders and base registers, using no multipliers. Results SHALL truncate modulo 2^AW (2^WW for wa).
REQ-023 SHALL drive `v_valid`=1 in RUN only. A step advances only when `v_valid`&`v_ready`.
REQ-024 SHALL hold every step output stable while `v_ready`=0.
REQ-025 SHALL assert `first` on c=ky=kx=0, or on the bias step when one exists. SHALL assert `lastt` on c=id, ky=kh, kx=kw.
REQ-026 SHALL, on acceptance of the final step (all loops at max), go to DONE. DONE SHALL assert `done` for exactly one cycle with `v_valid`=0, then go to IDLE.
REQ-027 SHALL, if `run`=0 in RUN, go to IDLE on the next edge without asserting `done`. A handshake completing in the same cycle is still counted as accepted.
REQ-028 SHALL present the first step in the first RUN cycle, giving start-to-first-valid latency of 2 cycles from the `run` rise.
REQ-029 SHALL sustain one step per cycle while `v_ready`=1.

Reset
REQ-030 SHALL, on `reset`, put the FSM in IDLE and clear all counters, base registers, the captured `run` and every output to 0, asynchronously.
REQ-031 SHALL treat reset asserted mid-layer as an abort. The next layer SHALL require a fresh `run` rising edge.

Configuration
REQ-032 SHALL support macro TINY_DNN_CTRL_BIAS_EN.
- Defined, with `enbias`=1: one extra step precedes the taps of each pixel, with `bias`=1, `first`=1, wa=d, ia=0 and oa as for the pixel.
- Undefined: `enbias` is ignored and `bias` is tied to 0.

Structure
REQ-033 SHALL place the FSM state enum and the AW/WW defaults in shared package tiny_dnn_pkg.
REQ-034 SHALL use sub-module tiny_dnn_cnt: a wrap counter with enable, max input, value output and carry output, instantiated once per loop.

Verification
REQ-035 All config 0, v_ready=1, run 0->1 -> one step with ia=wa=oa=0, first=lastt=1; `done` pulses 2 cycles later.
REQ-036 iw=ih=2, kh=kw=1, others 0 -> ia sequence 0,1,3,4; wa sequence 0,1,2,3; lastt on the 4th step.
REQ-037 As REQ-036 plus ow=1 -> second pixel ia sequence 1,2,4,5 with oa=1.
REQ-038 v_ready low for 5 cycles mid-layer -> ia/wa/oa/first/lastt unchanged throughout; sequence resumes with no step lost.
REQ-039 run dropped after 3 accepted steps -> busy=0 next cycle and no `done`; a new run rise restarts at ia=wa=oa=0.
REQ-040 With TINY_DNN_CTRL_BIAS_EN defined, enbias=1, od=1, other config 0 -> steps (bias,wa=0), (tap,wa=0), (bias,wa=1), (tap,wa=fs).
